// File: rtl/mem_access_pkg.sv
// Shared memory-op encodings, bus size codes and helpers used by decode, EX and MEM.
package mem_access_pkg;

   typedef enum logic [3:0] {
      MEM_NONE = 4'd0,
      MEM_LB   = 4'd1,
      MEM_LBU  = 4'd2,
      MEM_LH   = 4'd3,
      MEM_LHU  = 4'd4,
      MEM_LW   = 4'd5,
      MEM_SB   = 4'd6,
      MEM_SH   = 4'd7,
      MEM_SW   = 4'd8
   } mem_op_t;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_DONE  = 3'd3,
      ST_DRAIN = 3'd4
   } ma_state_t;

   function automatic logic op_is_load(input logic [3:0] op);
      case (op)
         MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW: op_is_load = 1'b1;
         default:                                  op_is_load = 1'b0;
      endcase
   endfunction

   function automatic logic op_is_store(input logic [3:0] op);
      case (op)
         MEM_SB, MEM_SH, MEM_SW: op_is_store = 1'b1;
         default:                op_is_store = 1'b0;
      endcase
   endfunction

   function automatic logic [1:0] op_size(input logic [3:0] op);
      case (op)
         MEM_LB, MEM_LBU, MEM_SB: op_size = SIZE_BYTE;
         MEM_LH, MEM_LHU, MEM_SH: op_size = SIZE_HALF;
         default:                 op_size = SIZE_WORD;
      endcase
   endfunction

   function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] addr_lo);
      case (op)
         MEM_LH, MEM_LHU, MEM_SH: op_misaligned = addr_lo[0];
         MEM_LW, MEM_SW:          op_misaligned = (addr_lo != 2'd0);
         default:                 op_misaligned = 1'b0;
      endcase
   endfunction

   // Narrow stores replicate across all lanes so the SRAM can pick any lane by address.
   function automatic logic [31:0] store_wdata(input logic [3:0] op, input logic [31:0] sd);
      case (op)
         MEM_SB:  store_wdata = {4{sd[7:0]}};
         MEM_SH:  store_wdata = {2{sd[15:0]}};
         default: store_wdata = sd;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_load_ext.sv
// Picks the addressed byte/half of a load word and sign- or zero-extends it.
// Purely combinational; LW and non-load ops pass the word through raw.
module load_ext
   import mem_access_pkg::*;
(
   input  logic [3:0]  i_op,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_rdata,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_rdata[7:0];
      case (i_addr_lo)
         2'd0:    w_byte = i_rdata[7:0];
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         default: w_byte = i_rdata[31:24];
      endcase
   end

   assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

   always_comb begin
      o_data = i_rdata;
      case (i_op)
         MEM_LB:  o_data = {{24{w_byte[7]}}, w_byte};
         MEM_LBU: o_data = {24'd0, w_byte};
         MEM_LH:  o_data = {{16{w_half[15]}}, w_half};
         MEM_LHU: o_data = {16'd0, w_half};
         default: o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// MEM stage: drives an SRAM-like data bus, stalls IF..MEM while an access is in flight,
// raises address-error exceptions and extracts load data for the MEM/WB register.
module mem_access
   import mem_access_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic [31:0] ex_pc,
   input  logic [4:0]  ex_w_addr,
   input  logic        ex_we,
   input  logic [31:0] ex_w_data,
   input  logic [3:0]  ex_mem_op,
   input  logic [31:0] ex_mem_addr,
   input  logic [31:0] ex_store_data,
   input  logic        flush,
   input  logic        wb_pause,
   output logic        data_req,
   output logic        data_wr,
   output logic [1:0]  data_size,
   output logic [31:0] data_addr,
   output logic [31:0] data_wdata,
   input  logic        data_addr_ok,
   input  logic [31:0] data_rdata,
   input  logic        data_data_ok,
   output logic [31:0] mem_pc,
   output logic [4:0]  mem_w_addr,
   output logic        mem_we,
   output logic [31:0] mem_w_data,
   output logic        stall_req,
   output logic        exc_adel,
   output logic        exc_ades,
   output logic [31:0] badvaddr
);

   ma_state_t   r_state;
   logic [3:0]  r_op;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [1:0]  r_size;
   logic        r_wr;
   logic [31:0] r_rdata;

   logic        w_is_load;
   logic        w_is_store;
   logic        w_misalign;
   logic        w_exc;
   logic        w_accept;
   logic        w_stall;
   logic [31:0] w_load_data;

   assign w_is_load  = op_is_load(ex_mem_op);
   assign w_is_store = op_is_store(ex_mem_op);
   assign w_misalign = op_misaligned(ex_mem_op, ex_mem_addr[1:0]);
   assign w_exc      = ex_valid & w_misalign;
   assign w_accept   = (r_state == ST_IDLE) & ex_valid & (w_is_load | w_is_store)
                       & ~w_misalign & ~flush;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_op    <= MEM_NONE;
         r_addr  <= 32'd0;
         r_wdata <= 32'd0;
         r_size  <= SIZE_BYTE;
         r_wr    <= 1'b0;
         r_rdata <= 32'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_state <= ST_REQ;
                  r_op    <= ex_mem_op;
                  r_addr  <= ex_mem_addr;
                  r_wdata <= store_wdata(ex_mem_op, ex_store_data);
                  r_size  <= op_size(ex_mem_op);
                  r_wr    <= w_is_store;
               end
            end
            ST_REQ: begin
               // An accepted address with no data yet must be drained even if flushed.
               if (flush) begin
                  if (data_addr_ok && !data_data_ok)
                     r_state <= ST_DRAIN;
                  else
                     r_state <= ST_IDLE;
               end else if (data_addr_ok) begin
                  if (data_data_ok) begin
                     r_state <= ST_DONE;
                     r_rdata <= data_rdata;
                  end else begin
                     r_state <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (data_data_ok) begin
                  if (flush) begin
                     r_state <= ST_IDLE;
                  end else begin
                     r_state <= ST_DONE;
                     r_rdata <= data_rdata;
                  end
               end else if (flush) begin
                  r_state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (data_data_ok)
                  r_state <= ST_IDLE;
            end
            ST_DONE: begin
               if (!wb_pause)
                  r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      w_stall = 1'b0;
      case (r_state)
         ST_IDLE:                   w_stall = w_accept;
         ST_REQ, ST_WAIT, ST_DRAIN: w_stall = 1'b1;
         default:                   w_stall = 1'b0;
      endcase
   end

   load_ext u_load_ext (
      .i_op      (r_op),
      .i_addr_lo (r_addr[1:0]),
      .i_rdata   (r_rdata),
      .o_data    (w_load_data)
   );

   assign stall_req  = rst & w_stall;
   assign data_req   = rst & (r_state == ST_REQ);
   assign data_wr    = r_wr;
   assign data_size  = r_size;
   assign data_addr  = r_addr;
   assign data_wdata = r_wdata;

   assign exc_adel = rst & w_exc & w_is_load;
   assign exc_ades = rst & w_exc & w_is_store;
   assign badvaddr = ex_mem_addr;

   assign mem_pc     = ex_pc;
   assign mem_w_addr = ex_w_addr;
   assign mem_w_data = ((r_state == ST_DONE) && op_is_load(r_op)) ? w_load_data : ex_w_data;
   // MEM/WB takes a bubble while the stage is stalled, so no stale writeback leaks out.
   assign mem_we     = rst & ex_we & ex_valid & ~w_exc & ~flush & ~w_stall;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: bus handshakes, load extraction, stores, exceptions, flush and reset.
`timescale 1ns/1ps
module tb_mem_access;
   import mem_access_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic [4:0]  ex_w_addr;
   logic        ex_we;
   logic [31:0] ex_w_data;
   logic [3:0]  ex_mem_op;
   logic [31:0] ex_mem_addr;
   logic [31:0] ex_store_data;
   logic        flush;
   logic        wb_pause;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic [31:0] data_rdata;
   logic        data_data_ok;
   logic [31:0] mem_pc;
   logic [4:0]  mem_w_addr;
   logic        mem_we;
   logic [31:0] mem_w_data;
   logic        stall_req;
   logic        exc_adel;
   logic        exc_ades;
   logic [31:0] badvaddr;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] addr;
      logic [31:0] rd;
      logic [31:0] exp;
      logic [1:0]  size;
   } vec_t;

   always #5 clk = ~clk;

   mem_access dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_w_addr(ex_w_addr),
      .ex_we(ex_we), .ex_w_data(ex_w_data), .ex_mem_op(ex_mem_op), .ex_mem_addr(ex_mem_addr),
      .ex_store_data(ex_store_data), .flush(flush), .wb_pause(wb_pause),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_rdata(data_rdata),
      .data_data_ok(data_data_ok), .mem_pc(mem_pc), .mem_w_addr(mem_w_addr), .mem_we(mem_we),
      .mem_w_data(mem_w_data), .stall_req(stall_req), .exc_adel(exc_adel), .exc_ades(exc_ades),
      .badvaddr(badvaddr)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      ex_valid = 0; ex_pc = 0; ex_w_addr = 0; ex_we = 0; ex_w_data = 0;
      ex_mem_op = MEM_NONE; ex_mem_addr = 0; ex_store_data = 0;
      flush = 0; wb_pause = 0; data_addr_ok = 0; data_rdata = 0; data_data_ok = 0;
   endtask

   task automatic test_reset();
      quiet(); rst = 0;
      ex_valid = 1; ex_we = 1; ex_mem_op = MEM_LW; ex_mem_addr = 32'h102;
      tick(); tick();
      @(negedge clk);
      total++; if (exc_adel !== 1'b0) begin bad++; $display("FAIL rst_adel got=%0b exp=0", exc_adel); end
      total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0b exp=0", stall_req); end
      total++; if (data_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%0b exp=0", data_req); end
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%0b exp=0", mem_we); end
      tick();
      rst = 1; quiet();
      @(negedge clk);
      total++; if (stall_req !== 1'b0 || data_req !== 1'b0) begin bad++; $display("FAIL rst_release got=%0b%0b exp=00", stall_req, data_req); end
      tick();
   endtask

   task automatic test_nonmem();
      quiet(); ex_valid = 1; ex_we = 1; ex_w_data = 32'h1234_5678; ex_pc = 32'h400;
      ex_w_addr = 5'd7; ex_mem_addr = 32'h3;
      @(negedge clk);
      total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL nm_stall got=%0b exp=0", stall_req); end
      total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL nm_we got=%0b exp=1", mem_we); end
      total++; if (mem_w_data !== 32'h1234_5678) begin bad++; $display("FAIL nm_wdata got=%h exp=12345678", mem_w_data); end
      total++; if (mem_pc !== 32'h400 || mem_w_addr !== 5'd7) begin bad++; $display("FAIL nm_pass got=%h/%0d exp=400/7", mem_pc, mem_w_addr); end
      total++; if (exc_adel !== 1'b0 || exc_ades !== 1'b0) begin bad++; $display("FAIL nm_exc got=%0b%0b exp=00", exc_adel, exc_ades); end
      tick();
      flush = 1;
      @(negedge clk);
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL nm_flush_we got=%0b exp=0", mem_we); end
      total++; if (data_req !== 1'b0) begin bad++; $display("FAIL nm_req got=%0b exp=0", data_req); end
      tick();
   endtask

   task automatic test_lw();
      quiet(); ex_valid = 1; ex_mem_op = MEM_LW; ex_mem_addr = 32'h100; ex_we = 1;
      ex_w_addr = 5'd3; ex_w_data = 32'h5555_5555; ex_pc = 32'h8000_0010;
      @(negedge clk);
      total++; if (stall_req !== 1'b1) begin bad++; $display("FAIL lw_stall_idle got=%0b exp=1", stall_req); end
      total++; if (data_req !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL lw_idle_req_we got=%0b%0b exp=00", data_req, mem_we); end
      tick();
      data_addr_ok = 1;
      @(negedge clk);
      total++; if (data_req !== 1'b1) begin bad++; $display("FAIL lw_req got=%0b exp=1", data_req); end
      total++; if (data_addr !== 32'h100 || data_size !== 2'd2 || data_wr !== 1'b0) begin bad++; $display("FAIL lw_bus got=%h/%0d/%0b exp=100/2/0", data_addr, data_size, data_wr); end
      total++; if (stall_req !== 1'b1) begin bad++; $display("FAIL lw_stall_req got=%0b exp=1", stall_req); end
      tick();
      data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      total++; if (stall_req !== 1'b1 || data_req !== 1'b0) begin bad++; $display("FAIL lw_wait got=%0b%0b exp=10", stall_req, data_req); end
      tick();
      data_data_ok = 0; data_rdata = 32'h0;
      @(negedge clk);
      total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL lw_stall_done got=%0b exp=0", stall_req); end
      total++; if (mem_w_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_data got=%h exp=deadbeef", mem_w_data); end
      total++; if (mem_we !== 1'b1 || mem_w_addr !== 5'd3) begin bad++; $display("FAIL lw_we got=%0b/%0d exp=1/3", mem_we, mem_w_addr); end
      tick();
      quiet();
      @(negedge clk);
      total++; if (stall_req !== 1'b0 || data_req !== 1'b0) begin bad++; $display("FAIL lw_after got=%0b%0b exp=00", stall_req, data_req); end
      tick();
   endtask

   task automatic test_load_ext();
      vec_t lv[8];
      lv[0] = '{MEM_LB,  32'h103, 32'h80FF_FF12, 32'hFFFF_FF80, 2'd0};
      lv[1] = '{MEM_LBU, 32'h103, 32'h80FF_FF12, 32'h0000_0080, 2'd0};
      lv[2] = '{MEM_LHU, 32'h102, 32'h80FF_FF12, 32'h0000_80FF, 2'd1};
      lv[3] = '{MEM_LH,  32'h102, 32'h80FF_FF12, 32'hFFFF_80FF, 2'd1};
      lv[4] = '{MEM_LB,  32'h100, 32'h80FF_FF12, 32'h0000_0012, 2'd0};
      lv[5] = '{MEM_LH,  32'h100, 32'h80FF_FF12, 32'hFFFF_FF12, 2'd1};
      lv[6] = '{MEM_LBU, 32'h101, 32'h80FF_FF12, 32'h0000_00FF, 2'd0};
      lv[7] = '{MEM_LW,  32'h104, 32'h1357_9BDF, 32'h1357_9BDF, 2'd2};
      for (int i = 0; i < 8; i++) begin
         quiet(); ex_valid = 1; ex_we = 1; ex_w_addr = 5'd9; ex_w_data = 32'hCAFE_0000;
         ex_mem_op = lv[i].op; ex_mem_addr = lv[i].addr;
         @(negedge clk);
         total++; if (stall_req !== 1'b1 || exc_adel !== 1'b0) begin bad++; $display("FAIL ld%0d_accept got=%0b%0b exp=10", i, stall_req, exc_adel); end
         tick();
         data_addr_ok = 1; data_data_ok = 1; data_rdata = lv[i].rd;
         @(negedge clk);
         total++; if (data_req !== 1'b1 || data_size !== lv[i].size) begin bad++; $display("FAIL ld%0d_req got=%0b/%0d exp=1/%0d", i, data_req, data_size, lv[i].size); end
         tick();
         data_addr_ok = 0; data_data_ok = 0; data_rdata = 32'h0;
         @(negedge clk);
         total++; if (mem_w_data !== lv[i].exp) begin bad++; $display("FAIL ld%0d_data got=%h exp=%h", i, mem_w_data, lv[i].exp); end
         total++; if (stall_req !== 1'b0 || mem_we !== 1'b1) begin bad++; $display("FAIL ld%0d_done got=%0b%0b exp=01", i, stall_req, mem_we); end
         tick();
      end
      quiet();
   endtask

   task automatic test_misalign();
      logic [3:0]  ops[5];
      logic [31:0] adr[5];
      logic        ld[5];
      ops[0] = MEM_SH;  adr[0] = 32'h101; ld[0] = 0;
      ops[1] = MEM_LW;  adr[1] = 32'h102; ld[1] = 1;
      ops[2] = MEM_LH;  adr[2] = 32'h103; ld[2] = 1;
      ops[3] = MEM_SW;  adr[3] = 32'h201; ld[3] = 0;
      ops[4] = MEM_LHU; adr[4] = 32'h001; ld[4] = 1;
      for (int i = 0; i < 5; i++) begin
         quiet(); ex_valid = 1; ex_we = 1; ex_mem_op = ops[i]; ex_mem_addr = adr[i];
         ex_store_data = 32'h1234_5678;
         for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++; if (exc_adel !== ld[i] || exc_ades !== !ld[i]) begin bad++; $display("FAIL mis%0d_exc got=%0b%0b exp=%0b%0b", i, exc_adel, exc_ades, ld[i], !ld[i]); end
            total++; if (badvaddr !== adr[i]) begin bad++; $display("FAIL mis%0d_bva got=%h exp=%h", i, badvaddr, adr[i]); end
            total++; if (data_req !== 1'b0 || stall_req !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL mis%0d_quiet got=%0b%0b%0b exp=000", i, data_req, stall_req, mem_we); end
            tick();
         end
      end
      quiet();
   endtask

   task automatic test_store();
      logic [3:0]  ops[3];
      logic [31:0] sd[3];
      logic [31:0] wd[3];
      logic [31:0] adr[3];
      logic [1:0]  sz[3];
      ops[0] = MEM_SB; sd[0] = 32'h0000_00AB; wd[0] = 32'hABAB_ABAB; adr[0] = 32'h200; sz[0] = 2'd0;
      ops[1] = MEM_SH; sd[1] = 32'h1234_CDEF; wd[1] = 32'hCDEF_CDEF; adr[1] = 32'h202; sz[1] = 2'd1;
      ops[2] = MEM_SW; sd[2] = 32'h89AB_CDEF; wd[2] = 32'h89AB_CDEF; adr[2] = 32'h204; sz[2] = 2'd2;
      for (int i = 0; i < 3; i++) begin
         quiet(); ex_valid = 1; ex_mem_op = ops[i]; ex_mem_addr = adr[i]; ex_store_data = sd[i];
         tick();
         for (int c = 0; c < 2; c++) begin
            data_addr_ok = (c == 1); data_data_ok = (c == 1);
            @(negedge clk);
            total++; if (data_req !== 1'b1 || data_wr !== 1'b1) begin bad++; $display("FAIL st%0d_req got=%0b%0b exp=11", i, data_req, data_wr); end
            total++; if (data_wdata !== wd[i] || data_size !== sz[i] || data_addr !== adr[i]) begin bad++; $display("FAIL st%0d_bus got=%h/%0d/%h exp=%h/%0d/%h", i, data_wdata, data_size, data_addr, wd[i], sz[i], adr[i]); end
            tick();
         end
         data_addr_ok = 0; data_data_ok = 0;
         @(negedge clk);
         total++; if (stall_req !== 1'b0 || data_req !== 1'b0) begin bad++; $display("FAIL st%0d_done got=%0b%0b exp=00", i, stall_req, data_req); end
         tick();
      end
      quiet();
   endtask

   task automatic test_wb_pause();
      quiet(); ex_valid = 1; ex_we = 1; ex_mem_op = MEM_LW; ex_mem_addr = 32'h104;
      tick();
      data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'h0BAD_F00D;
      tick();
      data_addr_ok = 0; data_data_ok = 0; data_rdata = 32'h0; wb_pause = 1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         total++; if (mem_w_data !== 32'h0BAD_F00D) begin bad++; $display("FAIL wbp%0d_data got=%h exp=0badf00d", c, mem_w_data); end
         total++; if (stall_req !== 1'b0 || data_req !== 1'b0) begin bad++; $display("FAIL wbp%0d_ctl got=%0b%0b exp=00", c, stall_req, data_req); end
         tick();
      end
      wb_pause = 0;
      tick();
      quiet(); ex_valid = 1; ex_w_data = 32'h0000_0042;
      @(negedge clk);
      total++; if (mem_w_data !== 32'h0000_0042) begin bad++; $display("FAIL wbp_idle got=%h exp=00000042", mem_w_data); end
      tick();
      quiet();
   endtask

   task automatic test_flush_drain();
      quiet(); ex_valid = 1; ex_we = 1; ex_mem_op = MEM_LW; ex_mem_addr = 32'h100;
      tick();
      data_addr_ok = 1;
      tick();
      data_addr_ok = 0; flush = 1;
      @(negedge clk);
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL fl_wait_we got=%0b exp=0", mem_we); end
      tick();
      quiet();
      for (int c = 0; c < 3; c++) begin
         data_data_ok = (c == 2); data_rdata = (c == 2) ? 32'hBADB_AD00 : 32'h0;
         @(negedge clk);
         total++; if (data_req !== 1'b0 || stall_req !== 1'b1) begin bad++; $display("FAIL fl_drain%0d got=%0b%0b exp=01", c, data_req, stall_req); end
         tick();
      end
      quiet(); ex_valid = 1; ex_we = 1; ex_w_data = 32'h0000_0777;
      @(negedge clk);
      total++; if (stall_req !== 1'b0 || mem_w_data !== 32'h0000_0777) begin bad++; $display("FAIL fl_idle got=%0b/%h exp=0/00000777", stall_req, mem_w_data); end
      tick();
      quiet(); ex_valid = 1; ex_we = 1; ex_mem_op = MEM_LW; ex_mem_addr = 32'h108;
      tick();
      data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'h1122_3344;
      @(negedge clk);
      total++; if (data_req !== 1'b1) begin bad++; $display("FAIL fl_next_req got=%0b exp=1", data_req); end
      tick();
      data_addr_ok = 0; data_data_ok = 0; data_rdata = 32'h0;
      @(negedge clk);
      total++; if (mem_w_data !== 32'h1122_3344 || mem_we !== 1'b1) begin bad++; $display("FAIL fl_next_data got=%h/%0b exp=11223344/1", mem_w_data, mem_we); end
      tick();
      quiet();
   endtask

   task automatic test_req_flush();
      quiet(); ex_valid = 1; ex_we = 1; ex_mem_op = MEM_LBU; ex_mem_addr = 32'h400;
      tick();
      flush = 1;
      @(negedge clk);
      total++; if (data_req !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("FAIL rf_req got=%0b%0b exp=10", data_req, mem_we); end
      tick();
      quiet();
      @(negedge clk);
      total++; if (data_req !== 1'b0 || stall_req !== 1'b0) begin bad++; $display("FAIL rf_idle got=%0b%0b exp=00", data_req, stall_req); end
      tick();
   endtask

   task automatic test_reset_in_wait();
      quiet(); ex_valid = 1; ex_we = 1; ex_mem_op = MEM_LW; ex_mem_addr = 32'h300;
      tick();
      data_addr_ok = 1;
      tick();
      data_addr_ok = 0; rst = 0;
      @(negedge clk);
      total++; if (stall_req !== 1'b0 || data_req !== 1'b0) begin bad++; $display("FAIL rw_inrst got=%0b%0b exp=00", stall_req, data_req); end
      tick();
      rst = 1; quiet();
      @(negedge clk);
      total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL rw_idle got=%0b exp=0", stall_req); end
      tick();
      ex_valid = 1; ex_we = 1; ex_w_data = 32'h0000_1111;
      data_data_ok = 1; data_rdata = 32'h7777_7777;
      @(negedge clk);
      total++; if (mem_w_data !== 32'h0000_1111 || stall_req !== 1'b0) begin bad++; $display("FAIL rw_late got=%h/%0b exp=00001111/0", mem_w_data, stall_req); end
      tick();
      quiet();
      @(negedge clk);
      total++; if (data_req !== 1'b0 || stall_req !== 1'b0) begin bad++; $display("FAIL rw_after got=%0b%0b exp=00", data_req, stall_req); end
      ex_valid = 1; ex_we = 1; ex_mem_op = MEM_LW; ex_mem_addr = 32'h304;
      tick();
      data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'hA5A5_0F0F;
      tick();
      data_addr_ok = 0; data_data_ok = 0; data_rdata = 32'h0;
      @(negedge clk);
      total++; if (mem_w_data !== 32'hA5A5_0F0F) begin bad++; $display("FAIL rw_next got=%h exp=a5a50f0f", mem_w_data); end
      tick();
      quiet();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 0;
      quiet();
      tick();
      test_reset();
      test_nonmem();
      test_lw();
      test_load_ext();
      test_misalign();
      test_store();
      test_wb_pause();
      test_flush_drain();
      test_req_flush();
      test_reset_in_wait();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 clk  in  1  pipeline clock; all state SHALL update on posedge clk.
REQ-002 rst  in  1  reset, synchronous, active-low; clock clk.
REQ-003 ex_valid  in  1  EX/MEM register holds a live instruction.
REQ-004 ex_pc  in  32  instruction PC.
REQ-005 ex_w_addr  in  5  GPR destination; ex_we  in  1  GPR write enable; ex_w_data  in  32  non-load result.
REQ-006 ex_mem_op  in  4  MEM_NONE/LB/LBU/LH/LHU/LW/SB/SH/SW encoding from shared package.
REQ-007 ex_mem_addr  in  32  effective address; ex_store_data  in  32  rt value.
REQ-008 flush  in  1  exception/eret flush, same meaning as pipeline clear.
REQ-009 wb_pause  in  1  pause[4] from pipeline control (MEM/WB stalled).
REQ-010 data_req  out  1  SRAM-like request; data_wr  out  1  store; data_size  out  2  0=byte,1=half,2=word.
REQ-011 data_addr  out  32; data_wdata  out  32; data_addr_ok  in  1; data_rdata  in  32; data_data_ok  in  1.
REQ-012 mem_pc  out  32; mem_w_addr  out  5; mem_we  out  1; mem_w_data  out  32: feed MEM/WB register.
REQ-013 stall_req  out  1  request pipeline stall of IF..MEM.
REQ-014 exc_adel, exc_ades  out  1 each; badvaddr  out  32  faulting address.

Function
REQ-015 FSM states SHALL be IDLE, REQ, WAIT, DONE, DRAIN.
REQ-016 Misalignment: LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0 SHALL assert exc_adel (loads) or exc_ades (stores) combinationally with badvaddr=ex_mem_addr, no bus request, mem_we=0.
REQ-017 IDLE: ex_valid & mem op & aligned & !flush SHALL go to REQ next cycle; stall_req=1 that cycle.
REQ-018 REQ: data_req=1; data_addr, data_wr, data_size, data_wdata SHALL be stable until data_addr_ok.
REQ-019 REQ: addr_ok & data_ok same cycle -> DONE; addr_ok only -> WAIT; flush -> IDLE, request dropped.
REQ-020 WAIT: data_ok -> DONE, data_rdata captured; flush -> DRAIN.
REQ-021 DRAIN: data_req=0; data_ok -> IDLE, data discarded; no writeback ever for drained access.
REQ-022 DONE: stall_req=0; wb_pause=0 -> IDLE, else stay holding captured data.
REQ-023 stall_req SHALL be 1 in REQ, WAIT, DRAIN and in IDLE when REQ-017 condition holds; 0 otherwise.
REQ-024 Store write data: SB replicates byte x4, SH replicates half x2, SW passes through; data_addr=ex_mem_addr unmodified.
REQ-025 Load extraction: byte lane addr[1:0], half lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW raw.
REQ-026 mem_w_data SHALL be extracted load data in DONE for loads, else ex_w_data; mem_we=ex_we & ex_valid & no exception & !flush.
REQ-027 mem_pc, mem_w_addr SHALL pass ex_pc, ex_w_addr combinationally.
REQ-028 Minimum load latency: 3 cycles from IDLE accept to DONE with zero-wait bus (IDLE, REQ, DONE).
REQ-029 Non-memory instructions SHALL pass with zero added latency, stall_req=0.

Reset
REQ-030 rst=0 SHALL force state IDLE, captured data 0, data_req=0, stall_req=0, exc_adel=exc_ades=0; overrides flush and in-flight bus transaction.
REQ-031 A bus response arriving after reset SHALL be ignored (IDLE ignores data_ok).

Structure
REQ-032 MEM_* op encodings and SIZE_* constants SHALL live in defines package shared with decode and EX.
REQ-033 One sub-module load_ext (combinational byte/half select and extension) SHALL be instantiated.

Verification
REQ-034 LW addr 0x100, addr_ok cycle 1, data_ok cycle 2 rdata 0xDEADBEEF -> mem_w_data=0xDEADBEEF, stall_req 1,1,0.
REQ-035 LB addr 0x103 rdata 0x80FF_FF12 -> 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 -> 0x000080FF.
REQ-036 SH addr 0x101 -> exc_ades=1, badvaddr=0x101, data_req never 1, mem_we=0.
REQ-037 SB data 0x000000AB -> data_wdata=0xABABABAB, data_size=0, data_wr=1.
REQ-038 LW, flush in WAIT, data_ok 3 cycles later -> DRAIN then IDLE, mem_we=0, next LW completes normally.
REQ-039 rst=0 asserted in WAIT -> next cycle IDLE, stall_req=0; later data_ok ignored.
